// File: rtl/zbt_wr_buf_pkg.sv
// Shared video constants: pixel-pair width, ZBT address width and the
// default depth of the ZBT bank-1 write buffer.
package zbt_wr_buf_pkg;

    localparam int PIX_W        = 18;
    localparam int PIX_PAIR_W   = 2 * PIX_W;
    localparam int ZBT_ADDR_W   = 19;
    localparam int WR_BUF_DEPTH = 8;

endpackage

// File: rtl/zbt_wr_buf_sync_fifo.sv
// Synchronous FIFO: storage array, wrapping pointers, level counter and a
// registered read port. Callers only assert push/pop when legal (push when
// not full or popping, pop when not empty); clear empties the FIFO and wins
// over push/pop. The read register holds its value when not popping.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 55
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign wr_en = push && !clear;
    assign rd_en = pop && !clear;

    // Storage write; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Registered read: the popped entry appears the cycle after the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_data <= '0;
        end else if (rd_en) begin
            pop_data <= mem[rd_ptr];
        end
    end

    // Full/empty come from the level count, never from pointer equality.
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/zbt_wr_buf.sv
// ZBT bank-1 write buffer: queues {addr, data} pixel pairs from the edge
// stage and writes one per granted ZBT write slot.
//
// Handshake: in_valid has no ready; an input offered while full (and not
// popping that cycle) is dropped and sets the sticky overflow flag. wr_slot
// is a grant from the ZBT controller; it is consumed only when an entry is
// available, and the write appears on zbt_we/zbt_addr/zbt_data one cycle
// later. flush discards everything without counting as overflow.
module zbt_wr_buf
    import zbt_wr_buf_pkg::*;
#(
    parameter int DEPTH  = WR_BUF_DEPTH,
    parameter int DATA_W = PIX_PAIR_W,
    parameter int ADDR_W = ZBT_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic                   wr_slot,
    input  logic                   flush,
    output logic                   zbt_we,
    output logic [ADDR_W-1:0]      zbt_addr,
    output logic [DATA_W-1:0]      zbt_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int ENT_W = ADDR_W + DATA_W;

    logic             pop;
    logic             push;
    logic [ENT_W-1:0] rd_entry;

    // A slot pops only an entry already stored; flush cancels both sides.
    assign pop  = wr_slot && !empty && !flush;
    assign push = in_valid && (!full || pop) && !flush;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .pop       (pop),
        .push_data ({in_addr, in_data}),
        .pop_data  (rd_entry),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    // The FIFO read register doubles as the held ZBT address/data register.
    assign zbt_addr = rd_entry[ENT_W-1:DATA_W];
    assign zbt_data = rd_entry[DATA_W-1:0];

    // Write strobe follows the pop by one cycle, aligned with the read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            zbt_we <= 1'b0;
        end else begin
            zbt_we <= pop;
        end
    end

    // Sticky overflow: an offered input that was neither stored nor flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (in_valid && !push && !flush) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_zbt_wr_buf.sv
// Bench for zbt_wr_buf: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a queue-based model.
module tb_zbt_wr_buf;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 36;
    localparam int ADDR_W = 19;
    localparam int ENT_W  = ADDR_W + DATA_W;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;
    logic              wr_slot;
    logic              flush;
    logic              zbt_we;
    logic [ADDR_W-1:0] zbt_addr;
    logic [DATA_W-1:0] zbt_data;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;

    // Model state: queued entries in arrival order plus expected outputs.
    logic [ENT_W-1:0]  exp_q[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_ovf;
    bit                model_live = 0;

    logic [ADDR_W-1:0] wr_log[$];
    logic [ADDR_W-1:0] sent[$];

    int n_checks = 0;
    int n_fail   = 0;

    zbt_wr_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_addr  (in_addr),
        .wr_slot  (wr_slot),
        .flush    (flush),
        .zbt_we   (zbt_we),
        .zbt_addr (zbt_addr),
        .zbt_data (zbt_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    // Clock
    initial begin
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Model advance for one clock edge, from the inputs about to be sampled.
    task automatic model_step();
        bit do_pop;
        bit do_push;
        logic [ENT_W-1:0] ent;
        if (reset) begin
            exp_q.delete();
            m_we = 0; m_addr = '0; m_data = '0; m_ovf = 0;
            model_live = 1;
        end else if (flush) begin
            exp_q.delete();
            m_we = 0;
        end else begin
            do_pop  = wr_slot && (exp_q.size() > 0);
            do_push = in_valid && ((exp_q.size() < DEPTH) || do_pop);
            if (in_valid && !do_push) m_ovf = 1;
            m_we = do_pop;
            if (do_pop) begin
                ent = exp_q.pop_front();
                m_addr = ent[ENT_W-1:DATA_W];
                m_data = ent[DATA_W-1:0];
            end
            if (do_push) exp_q.push_back({in_addr, in_data});
        end
    endtask

    // Driver: apply inputs for one cycle; return just after the next negedge.
    task automatic drive(input logic rst, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic slot, input logic fl);
        reset = rst; in_valid = v; in_addr = a; in_data = d; wr_slot = slot; flush = fl;
        model_step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    // Scoreboard compare: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (model_live) begin
            chk("zbt_we",   64'(zbt_we),   64'(m_we));
            chk("zbt_addr", 64'(zbt_addr), 64'(m_addr));
            chk("zbt_data", 64'(zbt_data), 64'(m_data));
            chk("level",    64'(level),    64'(exp_q.size()));
            chk("full",     64'(full),     64'(exp_q.size() == DEPTH));
            chk("empty",    64'(empty),    64'(exp_q.size() == 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (zbt_we === 1'b1) wr_log.push_back(zbt_addr);
        end
    end

    initial begin
        reset = 1; in_valid = 0; in_addr = '0; in_data = '0; wr_slot = 0; flush = 0;
        drive(1, 0, '0, '0, 0, 0);
        drive(1, 0, '0, '0, 0, 0);

        // Reset state
        chk("rst_level", 64'(level), 0);
        chk("rst_we", 64'(zbt_we), 0);
        chk("rst_addr", 64'(zbt_addr), 0);
        chk("rst_data", 64'(zbt_data), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_full", 64'(full), 0);

        // Minimum latency: push at n with slot held, write at n+2.
        // 0xABCDE12345 does not fit 36 bits; its low 36 bits are used.
        drive(0, 1, 19'h00010, 36'hBCDE12345, 1, 0);
        chk("lat_n1_we", 64'(zbt_we), 0);
        chk("lat_n1_level", 64'(level), 1);
        drive(0, 0, '0, '0, 1, 0);
        chk("lat_n2_we", 64'(zbt_we), 1);
        chk("lat_n2_addr", 64'(zbt_addr), 64'h10);
        chk("lat_n2_data", 64'(zbt_data), 64'hBCDE12345);
        chk("lat_n2_level", 64'(level), 0);
        drive(0, 0, '0, '0, 1, 0);
        chk("hold_we", 64'(zbt_we), 0);
        chk("hold_addr", 64'(zbt_addr), 64'h10);

        // Fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) drive(0, 1, ADDR_W'(32'h100 + i), rnd_data(), 0, 0);
        chk("fill_full", 64'(full), 1);
        chk("fill_level", 64'(level), 8);
        drive(0, 1, 19'h1FF, rnd_data(), 0, 0);
        chk("ovf_set", 64'(overflow), 1);
        chk("ovf_level", 64'(level), 8);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, '0, '0, 1, 0);
            chk("drain_we", 64'(zbt_we), 1);
            chk("drain_addr", 64'(zbt_addr), 64'(32'h100 + i));
        end
        chk("drain_empty", 64'(empty), 1);

        // Full with simultaneous push and pop
        drive(1, 0, '0, '0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(0, 1, ADDR_W'(32'h200 + i), rnd_data(), 0, 0);
        drive(0, 1, 19'h2AA, rnd_data(), 1, 0);
        chk("pp_level", 64'(level), 8);
        chk("pp_ovf", 64'(overflow), 0);
        chk("pp_we", 64'(zbt_we), 1);
        chk("pp_addr", 64'(zbt_addr), 64'h200);

        // Flush at level 5 with push and slot requested
        drive(1, 0, '0, '0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, ADDR_W'(32'h400 + i), rnd_data(), 0, 0);
        chk("fl_pre_level", 64'(level), 5);
        drive(0, 1, 19'h4FF, rnd_data(), 1, 1);
        chk("fl_level", 64'(level), 0);
        chk("fl_we", 64'(zbt_we), 0);
        chk("fl_ovf", 64'(overflow), 0);

        // Reset mid-stream at level 3 with a write in flight
        for (int i = 0; i < DEPTH + 1; i++) drive(0, 1, ADDR_W'(32'h500 + i), rnd_data(), 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, '0, '0, 1, 0);
        chk("mr_pre_level", 64'(level), 3);
        chk("mr_pre_we", 64'(zbt_we), 1);
        chk("mr_pre_ovf", 64'(overflow), 1);
        drive(1, 1, 19'h5FF, rnd_data(), 1, 0);
        chk("mr_we", 64'(zbt_we), 0);
        chk("mr_level", 64'(level), 0);
        chk("mr_ovf", 64'(overflow), 0);
        chk("mr_addr", 64'(zbt_addr), 0);
        chk("mr_data", 64'(zbt_data), 0);

        // 20 entries with toggling slot; pointers wrap twice
        wr_log.delete();
        sent.delete();
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 0) begin
                sent.push_back(ADDR_W'(32'h600 + c / 2));
                drive(0, 1, ADDR_W'(32'h600 + c / 2), rnd_data(), 0, 0);
            end else begin
                drive(0, 0, '0, '0, 1, 0);
            end
        end
        for (int i = 0; i < 3; i++) drive(0, 0, '0, '0, 1, 0);
        chk("wrap_count", 64'(wr_log.size()), 20);
        for (int i = 0; i < 20; i++) begin
            chk("wrap_addr", (i < wr_log.size()) ? 64'(wr_log[i]) : 64'hDEAD, 64'(32'h600 + i));
        end

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 65,
                  ADDR_W'($urandom()),
                  rnd_data(),
                  $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 3);
        end
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 0, '0, '0, 1, 0);
        chk("final_empty", 64'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zbt_wr_buf.md
ZBT_WR_BUF -- requirements
Module: zbt_wr_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 36, meaning the two-pixel word width (2 x 18-bit pixels).
REQ-003 SHALL have parameter ADDR_W, default 19, meaning the ZBT word address width.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  processed pixel pair present this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  processed pixel pair from the edge-processing stage.
REQ-008 SHALL have port in_addr  input  ADDR_W  destination address in ZBT bank 1 for in_data.
REQ-009 SHALL have port wr_slot  input  1  the ZBT controller grants a write cycle this clock.
REQ-010 SHALL have port flush  input  1  discard all buffered entries (frame restart).
REQ-011 SHALL have port zbt_we  output  1  write strobe to ZBT bank 1.
REQ-012 SHALL have port zbt_addr  output  ADDR_W  write address.
REQ-013 SHALL have port zbt_data  output  DATA_W  write data.
REQ-014 SHALL have port full  output  1  level == DEPTH.
REQ-015 SHALL have port empty  output  1  level == 0.
REQ-016 SHALL have port level  output  log2(DEPTH)+1  current entry count.
REQ-017 SHALL have port overflow  output  1  sticky: at least one input dropped.

Function
REQ-018 SHALL store {in_addr, in_data} as one FIFO entry; order preserved.
REQ-019 SHALL push when in_valid=1 and (full=0 or a pop occurs the same cycle).
REQ-020 SHALL pop when wr_slot=1 and empty=0; an empty FIFO with wr_slot=1 does nothing.
REQ-021 SHALL register outputs: a pop in cycle n drives zbt_we=1 with the popped entry's addr/data in cycle n+1; otherwise zbt_we=0 at n+1.
REQ-022 SHALL hold zbt_addr/zbt_data at their last values when zbt_we=0.
REQ-023 SHALL make a pushed entry poppable no earlier than the cycle after the push (no fall-through); min in_valid-to-zbt_we latency = 2 cycles.
REQ-024 SHALL update level by +1 on push only, -1 on pop only, 0 on both or neither.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; full/empty derive from level, never from pointer equality alone.
REQ-026 SHALL set overflow and drop the input when in_valid=1, full=1, and no pop occurs that cycle; stored entries remain unchanged.
REQ-027 SHALL, on flush=1, zero level and both pointers, suppress any push and pop that cycle, drive zbt_we=0 next cycle, and leave overflow unchanged.
REQ-028 SHALL not set overflow for an input discarded by flush.

Reset
REQ-029 SHALL, with reset=1 at a clock edge, clear pointers, level=0, zbt_we=0, zbt_addr=0, zbt_data=0, and overflow=0; reset has priority over flush, push, and pop.
REQ-030 SHALL not require initialisation of the storage array; storage contents are don't-care after reset.

Structure
REQ-031 SHALL take DEPTH/DATA_W/ADDR_W defaults and the pixel-pair/ZBT-address width constants from the shared video package used by the ZBT and edge-processing blocks.
REQ-032 SHALL implement storage plus pointers as one sub-module, sync_fifo (registered read, level/full/empty); zbt_wr_buf adds the slot pop, output register, overflow, and flush.

Verification
REQ-033 SHALL cover: push addr=0x00010/data=0xABCDE12345 at n into an empty FIFO, wr_slot held 1 -> zbt_we=1 at n+2 with the same addr/data, level back to 0.
REQ-034 SHALL cover: 8 pushes, wr_slot=0 -> full=1, level=8; 9th push -> overflow=1, level=8; then 8 slots -> the first 8 addresses out in order, empty=1.
REQ-035 SHALL cover: full FIFO with in_valid=1 and wr_slot=1 in the same cycle -> push accepted, overflow stays 0, level stays 8.
REQ-036 SHALL cover: level=5, flush=1 with in_valid=1 and wr_slot=1 -> level=0 next cycle, zbt_we=0, overflow unchanged.
REQ-037 SHALL cover: reset asserted mid-stream at level=3 with zbt_we=1 -> next cycle zbt_we=0, level=0, overflow=0, outputs zero.
REQ-038 SHALL cover: 20 entries with wr_slot toggling every cycle and pointers wrapping twice -> all 20 written in order, none lost.
